modmul_mont: RTL and testbench
==============================

Name: modmul_mont

Overview:
- Pipelined word-level Montgomery modular multiplier.
- Sits directly upstream of the butterfly add/sub stage: it computes the twiddle product B*W*2^(-K*Reduc_param) mod q, and that result feeds modsub and modadd.
- Exploits NTT-friendly moduli of the form q = qH*2^Reduc_param + 1, so each reduction step needs only a narrow multiply by qH and no q^-1 constant.
- Twiddles are stored pre-scaled by 2^(K*Reduc_param) mod q, so the output is the plain product mod q.

Parameters:
- LOGQ, 64, modulus/operand width in bits.
- Reduc_param, 17, Montgomery digit width R; q[Reduc_param-1:1] must be zero and q[0] must be 1.
- TAGW, 8, width of sideband tag carried alongside each operand pair.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operand pair valid.
- in_ready  output  1  block can accept an operand pair this cycle.
- A  input  LOGQ  operand, required < q.
- B  input  LOGQ  twiddle (pre-scaled), required < q.
- q  input  LOGQ  modulus; quasi-static, changes only while the pipeline is empty.
- in_tag  input  TAGW  sideband, returned unchanged with the result.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts the result.
- C  output  LOGQ  A*B*2^(-K*R) mod q, in [0,q).
- out_tag  output  TAGW  tag of the result.

Behaviour:
- Constants:
  - K = ceil(LOGQ/Reduc_param), which is 4 for the defaults.
  - qH = q[LOGQ-1:Reduc_param].
- Stage 0 (P): register the full product P = A*B, 2*LOGQ bits.
- Stages 1..K (reduction), one per Montgomery step:
  - m = (-T) mod 2^R, taking the low R bits of the two's complement of T.
  - T_next = ((T + m) >> R) + m*qH. This is exact because m*q = m*qH*2^R + m.
  - Intermediate width is 2*LOGQ+1 bits, narrowing by R bits per stage to a minimum of LOGQ+2 bits. There is no truncation before the final stage.
- After stage K, T < 2q is guaranteed for A,B < q.
- Stage K+1 (final): C = T - q if T >= q, else T. Use a borrow-based compare (LOGQ+1 bit subtract, test the MSB).
- Latency: the result appears K+2 cycles after acceptance, with no stalls (6 cycles for the defaults). Throughput is one pair per cycle.
- Handshake:
  - advance = !out_valid || out_ready.
  - in_ready = advance.
  - A transfer occurs when in_valid && in_ready.
  - When advance is 0, every stage register, including the valid and tag bits, holds.
  - Bubbles propagate as valid=0. Data registers of invalid stages may update; this is don't-care.
- Each stage carries a valid bit and the tag; out_tag stays aligned with C.
- Reset (asynchronous, any time including mid-operation):
  - All valid bits clear, so out_valid=0 and in-flight results are discarded.
  - C=0 and out_tag=0.
  - in_ready=1 from the first cycle after rst_n rises.
- Boundaries:
  - A=0 or B=0 gives C=0.
  - T==q exactly at the final stage gives C=0.
  - C is held stable while out_valid && !out_ready.
  - A simultaneous accept and drain in the same cycle is a normal advance with no loss.
- Operands >= q are outside the contract and produce an undefined value. No error flag is raised.

Optional Feature:
- Macro: MODMUL_LAZY_EN.
- Defined:
  - The final conditional-subtract stage is removed; latency is K+1.
  - C is LOGQ bits holding T in [0,2q). This requires q < 2^(LOGQ-1) so that 2q fits in LOGQ bits.
  - Used only with lazy-tolerant consumers.
- Undefined (default): full reduction as above, latency K+2, C in [0,q).

Decomposition:
- Shared package ntt_pkg holds:
  - function calc_k(LOGQ,R) returning the stage count K.
  - Localparam widths for each stage's T register.
  - The tag/valid stage struct typedef.
- One natural sub-module, mont_step:
  - Combinational single reduction step with parameterized input width.
  - Inputs T and qH; output T_next.
  - Instantiated K times via generate, with a register per instance in the parent.

Test Plan:
- For all tests, q = 0xFFFFFFFF00000001 and defaults apply. 2^68 mod q = 0x0000000FFFFFFFF0.
- A=1, B=0x0000000FFFFFFFF0, tag=0x5A -> C=1, out_tag=0x5A, out_valid exactly 6 cycles after acceptance.
- A=q-1, B=0x0000000FFFFFFFF0 -> C=0xFFFFFFFF00000000. Then A=0, B=q-1 -> C=0.
- 1000 back-to-back random pairs with out_ready=1 -> one result per cycle, in order. Each result matches the reference model (A*B*inverse(2^68)) mod q, with tags in order.
- Random in_valid and out_ready toggling (30% stall) -> no loss or duplication; C and out_tag stable while stalled; in_ready == (!out_valid || out_ready).
- Three pairs in flight, then rst_n pulsed low mid-cycle -> out_valid=0 immediately; none of the three results ever appear; a new pair after release gives a correct result 6 cycles later.
- Directed T==q-at-final-stage case (solved from the model) -> C=0. With MODMUL_LAZY_EN: same stimulus -> C==q, latency 5.

Source files
------------

// File: rtl/ntt_pkg.sv
// Shared definitions for the NTT datapath blocks.
//
// Contents:
//   TAG_W          - sideband tag width carried by every pipeline stage
//   stage_ctl_t    - per-stage valid bit plus tag
//   calc_k()       - number of Montgomery digit steps K = ceil(logq / r)
//   calc_t_width() - width of the T register after a given number of reduction
//                    steps. It starts at 2*logq+1, narrows by r per step and
//                    never goes below logq+2.

package ntt_pkg;

   localparam int unsigned TAG_W = 8;

   typedef struct packed {
      logic             valid;
      logic [TAG_W-1:0] tag;
   } stage_ctl_t;

   function automatic int unsigned calc_k(input int unsigned logq, input int unsigned r);
      return (logq + r - 1) / r;
   endfunction

   function automatic int unsigned calc_t_width(input int unsigned logq, input int unsigned r,
                                                input int unsigned stage);
      int unsigned full_w;
      int unsigned floor_w;
      int unsigned drop_w;
      full_w  = 2 * logq + 1;
      floor_w = logq + 2;
      drop_w  = stage * r;
      if (drop_w + floor_w >= full_w) begin
         return floor_w;
      end
      return full_w - drop_w;
   endfunction

endpackage

// File: rtl/mont_step.sv
// One word-level Montgomery reduction step for moduli q = qH*2^R + 1.
//
// Computes T_next = (T + m*q) / 2^R with m = (-T) mod 2^R. Because
// m*q = m*qH*2^R + m, this is exactly ((T + m) >> R) + m*qH. No q^-1
// constant is needed. Purely combinational; the parent registers the result.
//
// Parameters:
//   LOGQ - modulus width
//   R    - digit width
//   WI   - width of the incoming T
//   WO   - width of the outgoing T (the caller guarantees the value fits)
// Ports:
//   t_i      - T from the previous stage
//   qh_i     - q[LOGQ-1:R]
//   t_next_o - reduced T

module mont_step #(
   parameter int unsigned LOGQ = 64,
   parameter int unsigned R    = 17,
   parameter int unsigned WI   = 129,
   parameter int unsigned WO   = 112
) (
   input  logic [WI-1:0]     t_i,
   input  logic [LOGQ-R-1:0] qh_i,
   output logic [WO-1:0]     t_next_o
);

   localparam int unsigned WS = WI + 1;

   logic [R-1:0]    m;
   logic [WS-1:0]   sum;
   logic [WS-1:0]   acc;
   logic [LOGQ-1:0] mqh;
   logic            unused_bits;

   always_comb begin
      m   = -t_i[R-1:0];
      // The low R bits of sum are zero by construction of m.
      sum = {1'b0, t_i} + {{(WS-R){1'b0}}, m};
      // m < 2^R and qH < 2^(LOGQ-R), so the product fits in LOGQ bits.
      mqh = {{(LOGQ-R){1'b0}}, m} * {{R{1'b0}}, qh_i};
      acc = {{R{1'b0}}, sum[WS-1:R]} + {{(WS-LOGQ){1'b0}}, mqh};
      t_next_o = acc[WO-1:0];
   end

   assign unused_bits = ^{sum[R-1:0], acc[WS-1:WO]};

endmodule

// File: rtl/modmul_mont.sv
// Pipelined Montgomery modular multiplier: C = A*B*2^(-K*R) mod q.
//
// Twiddles arrive pre-scaled by 2^(K*R) mod q, so C is the plain product
// A*B mod q. The result feeds the butterfly add/sub stage.
//
// Pipeline: stage 0 registers P = A*B. Stages 1..K each apply one mont_step.
// Stage K+1 does the conditional subtract into [0,q). Latency is K+2 and
// throughput is one pair per cycle. The whole pipe holds when the output is
// valid but not accepted.
//
// Build option MODMUL_LAZY_EN: drops the final subtract stage (latency K+1).
// C then holds T in [0,2q). This needs q < 2^(LOGQ-1).
//
// Ports:
//   clk, rst_n          - clock; asynchronous active-low reset
//   in_valid/in_ready   - operand handshake (A, B, in_tag)
//   A, B                - operands, both < q (B is the pre-scaled twiddle)
//   q                   - modulus; may change only while the pipe is empty
//   out_valid/out_ready - result handshake (C, out_tag)
//   C, out_tag          - result and the tag that came in with it
//
// TAGW must equal ntt_pkg::TAG_W, since the stage struct carries the tag.

module modmul_mont
   import ntt_pkg::*;
#(
   parameter int unsigned LOGQ        = 64,
   parameter int unsigned Reduc_param = 17,
   parameter int unsigned TAGW        = TAG_W
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [LOGQ-1:0] A,
   input  logic [LOGQ-1:0] B,
   input  logic [LOGQ-1:0] q,
   input  logic [TAGW-1:0] in_tag,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [LOGQ-1:0] C,
   output logic [TAGW-1:0] out_tag
);

   localparam int unsigned R   = Reduc_param;
   localparam int unsigned K   = calc_k(LOGQ, R);
   localparam int unsigned TKW = calc_t_width(LOGQ, R, K);
`ifdef MODMUL_LAZY_EN
   localparam int unsigned NSTAGE = K + 1;
`else
   localparam int unsigned NSTAGE = K + 2;
`endif

   logic                        advance;
   logic [LOGQ-R-1:0]           qh;
   stage_ctl_t                  ctl_in;
   stage_ctl_t [NSTAGE-1:0]     ctl_q;
   stage_ctl_t [NSTAGE-1:0]     ctl_d;
   logic [2*LOGQ-1:0]           p_q;
   logic [2*LOGQ-1:0]           p_d;
   logic [TKW-1:0]              t_fin;

   assign qh        = q[LOGQ-1:R];
   assign advance   = !ctl_q[NSTAGE-1].valid || out_ready;
   assign in_ready  = advance;
   assign out_valid = ctl_q[NSTAGE-1].valid;
   assign out_tag   = ctl_q[NSTAGE-1].tag;

   // Stage 0 and the valid/tag shift chain.
   always_comb begin
      ctl_in.valid = in_valid;
      ctl_in.tag   = in_tag;
      ctl_d        = ctl_q;
      p_d          = p_q;
      if (advance) begin
         ctl_d = {ctl_q[NSTAGE-2:0], ctl_in};
         p_d   = {{LOGQ{1'b0}}, A} * {{LOGQ{1'b0}}, B};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ctl_q <= '0;
         p_q   <= '0;
      end else begin
         ctl_q <= ctl_d;
         p_q   <= p_d;
      end
   end

   // Reduction stages 1..K. Each stage narrows T by R bits, down to LOGQ+2.
   for (genvar gi = 1; gi <= K; gi++) begin : gen_red
      localparam int unsigned WI = calc_t_width(LOGQ, R, gi - 1);
      localparam int unsigned WO = calc_t_width(LOGQ, R, gi);

      logic [WI-1:0] t_in;
      logic [WO-1:0] t_next;
      logic [WO-1:0] t_d;
      logic [WO-1:0] t_q;

      if (gi == 1) begin : gen_src_p
         assign t_in = {{(WI-2*LOGQ){1'b0}}, p_q};
      end else begin : gen_src_t
         assign t_in = gen_red[gi-1].t_q;
      end

      mont_step #(
         .LOGQ(LOGQ),
         .R   (R),
         .WI  (WI),
         .WO  (WO)
      ) u_step (
         .t_i     (t_in),
         .qh_i    (qh),
         .t_next_o(t_next)
      );

      always_comb begin
         t_d = advance ? t_next : t_q;
      end

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            t_q <= '0;
         end else begin
            t_q <= t_d;
         end
      end
   end

   assign t_fin = gen_red[K].t_q;

`ifdef MODMUL_LAZY_EN
   logic unused_bits;

   // T < 2q already; lazy consumers take it as is.
   assign C           = t_fin[LOGQ-1:0];
   assign unused_bits = ^{t_fin[TKW-1:LOGQ], q[R-1:0]};
`else
   logic [LOGQ:0]   diff;
   logic [LOGQ-1:0] c_d;
   logic [LOGQ-1:0] c_q;
   logic            unused_bits;

   // T < 2q < 2^(LOGQ+1), so an LOGQ+1 bit subtract is enough. The MSB is
   // set exactly when T < q, because it is the borrow.
   always_comb begin
      diff = t_fin[LOGQ:0] - {1'b0, q};
      c_d  = c_q;
      if (advance) begin
         c_d = diff[LOGQ] ? t_fin[LOGQ-1:0] : diff[LOGQ-1:0];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         c_q <= '0;
      end else begin
         c_q <= c_d;
      end
   end

   assign C           = c_q;
   assign unused_bits = ^t_fin[TKW-1:LOGQ+1];
`endif

endmodule

// File: tb/tb_modmul_mont.sv
// Bench for modmul_mont with q = 0xFFFFFFFF00000001 and default parameters.
// The reference is plain modular arithmetic: C = A*B*(2^68)^-1 mod q.

module tb_modmul_mont;

   localparam logic [63:0] QMOD = 64'hFFFFFFFF00000001;
   localparam logic [63:0] R68  = 64'h0000000FFFFFFFF0;  // 2^68 mod q
`ifdef MODMUL_LAZY_EN
   localparam int          LAT  = 5;
   localparam logic [63:0] TQ_EXP = QMOD;
`else
   localparam int          LAT  = 6;
   localparam logic [63:0] TQ_EXP = 64'd0;
`endif

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [63:0] A = '0;
   logic [63:0] B = '0;
   logic [63:0] qv = QMOD;
   logic [7:0]  in_tag = '0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [63:0] C;
   logic [7:0]  out_tag;

   modmul_mont dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .A        (A),
      .B        (B),
      .q        (qv),
      .in_tag   (in_tag),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .C        (C),
      .out_tag  (out_tag)
   );

   initial begin
      forever #5 clk = ~clk;
   end

   typedef struct {
      logic [63:0] c;
      logic [7:0]  tag;
      int          cyc;
      bit          lat_chk;
      bit          exact;
   } exp_t;

   exp_t        sb[$];
   exp_t        pop_e;
   exp_t        push_e;
   logic [63:0] pop_got;
   int          total = 0;
   int          bad = 0;
   int          cyc = 0;
   bit          check_lat = 1'b0;
   bit          stall_en = 1'b0;
   bit          cur_use_lit = 1'b0;
   bit          cur_exact = 1'b0;
   logic [63:0] cur_lit = '0;
   logic [63:0] rinv = 64'd1;
   bit          prev_stall = 1'b0;
   logic [63:0] prev_c = '0;
   logic [7:0]  prev_tag = '0;

   function automatic logic [63:0] mulmod(input logic [63:0] a, input logic [63:0] b);
      logic [127:0] p;
      p = {64'd0, a} * {64'd0, b};
      return 64'(p % {64'd0, QMOD});
   endfunction

   function automatic logic [63:0] model(input logic [63:0] a, input logic [63:0] b);
      return mulmod(mulmod(a, b), rinv);
   endfunction

   function automatic logic [63:0] rnd_op();
      logic [63:0] v;
      v = {$urandom, $urandom};
      if (v >= QMOD) v = v - QMOD;
      return v;
   endfunction

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h (t=%0t)", name, got, exp, $time);
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // Per-cycle checker, sampled on the falling edge.
   always @(negedge clk) begin
      if (!rst_n) begin
         sb.delete();
         prev_stall = 1'b0;
         check("reset_out_valid", 64'(out_valid), 64'd0);
         check("reset_C", C, 64'd0);
         check("reset_out_tag", 64'(out_tag), 64'd0);
      end else begin
         check("in_ready_rule", 64'(in_ready), 64'(!out_valid || out_ready));
         if (prev_stall) begin
            check("stall_hold_valid", 64'(out_valid), 64'd1);
            check("stall_hold_C", C, prev_c);
            check("stall_hold_tag", 64'(out_tag), 64'(prev_tag));
         end
         if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
               total++;
               bad++;
               $display("FAIL spurious_out: C=%0h tag=%0h but expected nothing", C, out_tag);
            end else begin
               pop_e   = sb.pop_front();
               pop_got = C;
`ifdef MODMUL_LAZY_EN
               if (!pop_e.exact && pop_got >= QMOD) pop_got = pop_got - QMOD;
`endif
               check("result_C", pop_got, pop_e.c);
               check("result_tag", 64'(out_tag), 64'(pop_e.tag));
               if (pop_e.lat_chk) check("latency", 64'(cyc - pop_e.cyc), 64'(LAT));
            end
         end
         if (in_valid && in_ready) begin
            push_e.c       = cur_use_lit ? cur_lit : model(A, B);
            push_e.tag     = in_tag;
            push_e.cyc     = cyc;
            push_e.lat_chk = check_lat && !stall_en;
            push_e.exact   = cur_exact;
            sb.push_back(push_e);
         end
         prev_stall = out_valid && !out_ready;
         prev_c     = C;
         prev_tag   = out_tag;
      end
   end

   // Downstream backpressure: 30% stall when enabled.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         out_ready = stall_en ? ($urandom_range(0, 99) >= 30) : 1'b1;
      end
   end

   task automatic send(input logic [63:0] a, input logic [63:0] b, input logic [7:0] t,
                       input bit use_lit, input logic [63:0] lit, input bit exact);
      bit acc;
      int n;
      A           = a;
      B           = b;
      in_tag      = t;
      cur_use_lit = use_lit;
      cur_lit     = lit;
      cur_exact   = exact;
      in_valid    = 1'b1;
      acc         = 1'b0;
      n           = 0;
      while (!acc && n < 200) begin
         @(negedge clk);
         acc = in_ready;
         @(posedge clk);
         #1;
         n++;
      end
      if (!acc) begin
         total++;
         bad++;
         $display("FAIL accept_timeout: in_ready stayed 0 for %0d cycles", n);
      end
   endtask

   task automatic idle();
      in_valid = 1'b0;
      @(posedge clk);
      #1;
   endtask

   task automatic drain(input int limit);
      int n;
      n        = 0;
      in_valid = 1'b0;
      while (sb.size() != 0 && n < limit) begin
         @(posedge clk);
         n++;
      end
      #1;
      check("drain_outstanding", 64'(sb.size()), 64'd0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // (2^68)^-1 = ((q+1)/2)^68 mod q
      repeat (68) rinv = mulmod(rinv, (QMOD >> 1) + 64'd1);
      check("model_pin_identity", model(64'd1, R68), 64'd1);
      check("model_pin_qm1", model(QMOD - 64'd1, R68), 64'hFFFFFFFF00000000);

      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Directed vectors with hand-computed results.
      check_lat = 1'b1;
      send(64'd1, R68, 8'h5A, 1'b1, 64'd1, 1'b0);
      send(QMOD - 64'd1, R68, 8'h11, 1'b1, 64'hFFFFFFFF00000000, 1'b0);
      send(64'd0, QMOD - 64'd1, 8'h22, 1'b1, 64'd0, 1'b0);
      send(64'h123456789ABCDEF0, 64'd0, 8'h33, 1'b1, 64'd0, 1'b0);
      // A=q, B=1: P=q and every step maps q to q, so T==q at the last stage.
      send(QMOD, 64'd1, 8'h44, 1'b1, TQ_EXP, 1'b1);
      drain(50);

      // Back-to-back stream, no stalls.
      for (int i = 0; i < 1000; i++) begin
         send(rnd_op(), rnd_op(), 8'(i), 1'b0, 64'd0, 1'b0);
      end
      drain(50);

      // Random bubbles on both sides.
      stall_en = 1'b1;
      for (int i = 0; i < 300; i++) begin
         if ($urandom_range(0, 99) < 30) idle();
         send(rnd_op(), rnd_op(), 8'(i + 7), 1'b0, 64'd0, 1'b0);
      end
      drain(500);
      stall_en = 1'b0;
      repeat (3) @(posedge clk);
      #1;

      // Reset with three pairs in flight.
      for (int i = 0; i < 3; i++) begin
         send(rnd_op(), rnd_op(), 8'(8'hA0 + i), 1'b0, 64'd0, 1'b0);
      end
      in_valid = 1'b0;
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      check("async_reset_out_valid", 64'(out_valid), 64'd0);
      check("async_reset_C", C, 64'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (10) idle();
      send(64'd5, R68, 8'h77, 1'b1, 64'd5, 1'b0);
      drain(50);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
